// File: rtl/ep_arb.sv
// Round-robin arbiter sharing the PCIe endpoint TX TRN interface between
// N requesters, with grant timeout, misuse detection and the TRN mux.
module ep_arb #(
    parameter int N           = 4,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_ep,
    input  logic [N-1:0]    drv_ep,
    output logic [N-1:0]    my_trn,
    input  logic [N*64-1:0] req_td,
    input  logic [N*8-1:0]  req_trem_n,
    input  logic [N-1:0]    req_tsof_n,
    input  logic [N-1:0]    req_teof_n,
    input  logic [N-1:0]    req_tsrc_rdy_n,
    output logic [N-1:0]    req_tdst_rdy_n,
    output logic [63:0]     trn_td,
    output logic [7:0]      trn_trem_n,
    output logic            trn_tsof_n,
    output logic            trn_teof_n,
    output logic            trn_tsrc_rdy_n,
    input  logic            trn_tdst_rdy_n,
    output logic            gnt_timeout,
    output logic            drv_err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [7:0]   TMO_LAST = 8'(GNT_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        OWNED
    } state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [7:0]    timer;

    logic          own_drv;
    logic          own_req;
    logic          live;
    logic [N-1:0]  own_mask;
    logic          err_c;
    logic          found;
    logic [IW-1:0] pick;

    assign own_drv = drv_ep[owner];
    assign own_req = req_ep[owner];
    assign live    = (state == OWNED) && own_drv;

    // Searching from last+1 keeps a just-released requester at lowest priority
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req_ep[(int'(last) + k) % N]) begin
                found = 1'b1;
                pick  = IW'((int'(last) + k) % N);
            end
        end
    end

    assign own_mask = (state == IDLE) ? '0 : (ONE << owner);
    assign err_c    = |(drv_ep & ~own_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            last        <= LAST_RST;
            timer       <= '0;
            my_trn      <= '0;
            gnt_timeout <= 1'b0;
            drv_err     <= 1'b0;
        end else begin
            gnt_timeout <= 1'b0;
            drv_err     <= err_c;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        owner  <= pick;
                        my_trn <= ONE << pick;
                        timer  <= '0;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (own_drv) begin
                        state <= OWNED;
                    end else if (!own_req) begin
                        my_trn <= '0;
                        last   <= owner;
                        state  <= IDLE;
                    end else if (timer == TMO_LAST) begin
                        my_trn      <= '0;
                        gnt_timeout <= 1'b1;
                        last        <= owner;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                OWNED: begin
                    if (!own_drv) begin
                        my_trn <= '0;
                        last   <= owner;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency path; falls back to idle framing as soon as drv_ep drops
    always_comb begin
        trn_td         = '0;
        trn_trem_n     = 8'hFF;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        req_tdst_rdy_n = '1;
        if (live) begin
            trn_td                = req_td[int'(owner)*64 +: 64];
            trn_trem_n            = req_trem_n[int'(owner)*8 +: 8];
            trn_tsof_n            = req_tsof_n[owner];
            trn_teof_n            = req_teof_n[owner];
            trn_tsrc_rdy_n        = req_tsrc_rdy_n[owner];
            req_tdst_rdy_n[owner] = trn_tdst_rdy_n;
        end
    end

endmodule

// File: doc/ep_arb.md
# ep_arb

Round-robin arbiter that shares the single PCIe endpoint TX TRN interface between N requester blocks (IRQ generator, DMA engines, completer). Requesters use the existing req_ep / my_trn / drv_ep handshake. The arbiter grants one owner at a time, watches for abandoned grants, and muxes the owner's TRN signals onto the core.

## Interface
- N, 4: number of requesters (2..8); index 0 wins the first arbitration after reset.
- GNT_TIMEOUT, 16: cycles a grant may wait for drv_ep before it is revoked (1..255).
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- req_ep  in  N  per-requester request level.
- drv_ep  in  N  per-requester "I am driving the TX interface" level.
- my_trn  out  N  one-hot grant, registered.
- req_td  in  N*64  requester data, requester i at [64i+63:64i].
- req_trem_n  in  N*8  requester remainder, requester i at [8i+7:8i].
- req_tsof_n, req_teof_n, req_tsrc_rdy_n  in  N each  requester framing.
- req_tdst_rdy_n  out  N  per-requester back-pressure.
- trn_td  out  64; trn_trem_n  out  8; trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n  out  1  to core.
- trn_tdst_rdy_n  in  1  from core.
- gnt_timeout  out  1  one-cycle pulse when a grant is revoked.
- drv_err  out  1  one-cycle pulse when any non-owner asserts drv_ep.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: my_trn[owner]=1, waiting for drv_ep[owner].
  - OWNED: owner drives the TRN interface.
- Registers: owner index, last index (reset N-1), grant timer of 8 bits.
- IDLE:
  - If any req_ep is set, pick the first set bit searching last+1, last+2, … modulo N.
  - Load owner, set my_trn[owner], clear the timer, go to GRANT.
- GRANT, evaluated in this priority order:
  - drv_ep[owner]=1 → OWNED; my_trn stays 1. The requester dropping req_ep on the same edge is legal.
  - req_ep[owner]=0 with drv_ep[owner]=0 (withdrawn) → clear my_trn, last=owner, IDLE.
  - timer==GNT_TIMEOUT-1 → clear my_trn, pulse gnt_timeout, last=owner, IDLE.
  - Otherwise timer+1.
- OWNED:
  - drv_ep[owner]=0 → clear my_trn, last=owner, IDLE.
  - No time limit on ownership.
- Mux, combinational from registered state/owner:
  - In OWNED with drv_ep[owner]=1: trn_* outputs = requester owner's signals, and req_tdst_rdy_n[owner]=trn_tdst_rdy_n.
  - Otherwise: trn_td=0, trn_trem_n=8'hFF, trn_tsof_n=trn_teof_n=trn_tsrc_rdy_n=1.
  - All non-owner req_tdst_rdy_n bits =1.
- drv_err:
  - Pulses for any drv_ep[j]=1 where j≠owner, or where the state is IDLE.
  - The offending signals are ignored and never reach the mux.
- Requests from a requester that was just released are not eligible ahead of others: round-robin from last+1.

## Timing
- Reset values: my_trn=0, gnt_timeout=0, drv_err=0, state IDLE, last=N-1.
  - The mux outputs immediately show idle values, including during async assertion mid-frame.
- Grant latency: req_ep sampled high on edge k (state IDLE) → my_trn high after edge k.
- Release: drv_ep low sampled on edge k → my_trn low after edge k. The state is IDLE for edge k+1, and the next grant appears after edge k+1.
  - Minimum one-cycle bubble between owners.
- Timeout: with drv_ep never asserted, my_trn is high for exactly GNT_TIMEOUT cycles. gnt_timeout pulses on the cycle after my_trn falls.
- Mux: zero-cycle path from requester to core while owned; no added pipeline.
- Simultaneous events:
  - Release and new requests on the same edge: the new grant waits for the IDLE cycle.
  - drv_ep and withdraw in GRANT: drv_ep wins.

## Test plan
- Single requester: req_ep[2]=1 at cycle 10, drv_ep[2] rises cycle 12, falls cycle 20.
  - my_trn[2] high on cycles 11–20 inclusive.
  - trn_td follows req_td[2] only while drv_ep[2]=1.
  - Idle values at all other times.
- Round-robin: req_ep=4'b1111 held, each owner holds drv_ep for 3 cycles.
  - Grant order 0,1,2,3,0.
  - One idle cycle between grants.
- Timeout: req_ep[1]=1, drv_ep never asserted, GNT_TIMEOUT=16.
  - my_trn[1] high for 16 cycles, then one gnt_timeout pulse.
  - Next grant goes to requester 2 if it is requesting.
- Withdraw: req_ep[3] drops 2 cycles after grant with no drv_ep.
  - my_trn[3] clears next edge, no gnt_timeout, last=3.
- Errors and back-pressure, while requester 0 owns:
  - drv_ep[1]=1 → drv_err pulses every cycle; trn_td stays requester 0's.
  - trn_tdst_rdy_n=1 for 4 cycles → only req_tdst_rdy_n[0] follows it; the other bits are held at 1.
- Async reset asserted in OWNED mid-frame → within the same cycle trn_tsrc_rdy_n=1; my_trn=0 after reset.
  - After release, req_ep=4'b1111 grants requester 0 first.
